// File: rtl/io_input_bank.sv
// io_input_bank: memory-mapped bank of NPORTS synchronised input ports.
// Each port is resynchronised, then reloaded into a port register every
// cycle. Changes seen at the port register are latched as sticky flags in
// STATUS (clear-on-read), and a registered interrupt is raised from the
// masked flags. Reads are combinational and decoded from addr[7:2].
module io_input_bank #(
    parameter int         NPORTS      = 4,
    parameter int         WIDTH       = 32,
    parameter int         SYNC_STAGES = 2,
    parameter logic [5:0] BASE_SEL    = 6'b110000
) (
    input  logic                    io_clk,
    input  logic                    reset,
    input  logic [31:0]             addr,
    input  logic                    rd,
    input  logic                    we,
    input  logic [31:0]             wdata,
    input  logic [NPORTS*WIDTH-1:0] in_port,
    output logic [31:0]             io_read_data,
    output logic                    irq
);

    // Register selects sitting directly above the port window.
    localparam logic [5:0] STATUS_SEL = BASE_SEL + 6'(NPORTS);
    localparam logic [5:0] MASK_SEL   = BASE_SEL + 6'(NPORTS + 1);

    logic [5:0]              sel;
    logic [NPORTS*WIDTH-1:0] in_flat;
    logic [NPORTS-1:0]       set_vec;
    logic [NPORTS-1:0]       chg_reg;
    logic [NPORTS-1:0]       chg_next;
    logic [NPORTS-1:0]       mask_reg;
    logic [NPORTS-1:0]       mask_next;
    logic                    irq_reg;
    logic                    irq_next;
    logic                    status_rd;
    logic                    mask_wr;
    logic                    unused_bits;

    assign sel = addr[7:2];

    // Address and write-data bits outside the decoded/stored fields.
    assign unused_bits = ^{addr[31:8], addr[1:0], wdata[31:NPORTS]};

    // Per-port synchroniser, port register and change detector.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
            logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
            logic [WIDTH-1:0] in_reg;

            // Shift the raw input through the synchroniser chain.
            always_ff @(posedge io_clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_reg[k] <= '0;
                    end
                end else begin
                    sync_reg[0] <= in_port[gi*WIDTH +: WIDTH];
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_reg[k] <= sync_reg[k-1];
                    end
                end
            end

            // Port register reloads from the last sync stage every cycle.
            always_ff @(posedge io_clk or posedge reset) begin
                if (reset) begin
                    in_reg <= '0;
                end else begin
                    in_reg <= sync_reg[SYNC_STAGES-1];
                end
            end

            // A flag is raised whenever the port register is about to change.
            assign set_vec[gi]                 = (sync_reg[SYNC_STAGES-1] != in_reg);
            assign in_flat[gi*WIDTH +: WIDTH]  = in_reg;
        end
    endgenerate

    // Next-state for flags, mask and interrupt; a new event beats a clear.
    always_comb begin
        status_rd = rd && (sel == STATUS_SEL);
        mask_wr   = we && (sel == MASK_SEL);
        chg_next  = (chg_reg & ~(status_rd ? chg_reg : '0)) | set_vec;
        mask_next = mask_wr ? wdata[NPORTS-1:0] : mask_reg;
        irq_next  = |(chg_next & mask_next);
    end

    // Sticky change flags, mask and registered interrupt.
    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            chg_reg  <= '0;
            mask_reg <= '0;
            irq_reg  <= 1'b0;
        end else begin
            chg_reg  <= chg_next;
            mask_reg <= mask_next;
            irq_reg  <= irq_next;
        end
    end

    // Combinational read mux; unmapped selects return zero.
    always_comb begin
        io_read_data = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (sel == BASE_SEL + 6'(i)) begin
                io_read_data = 32'(in_flat[i*WIDTH +: WIDTH]);
            end
        end
        if (sel == STATUS_SEL) begin
            io_read_data = 32'(chg_reg);
        end
        if (sel == MASK_SEL) begin
            io_read_data = 32'(mask_reg);
        end
    end

    assign irq = irq_reg;

endmodule

// File: tb/tb_io_input_bank.sv
// Randomised and directed bench for io_input_bank (default parameters),
// plus a narrow 2x8-bit instance for zero-extension and unmapped reads.
module tb_io_input_bank;

    localparam int NP   = 4;
    localparam int W    = 32;
    localparam int SYNC = 2;

    logic         io_clk = 1'b0;
    logic         reset  = 1'b1;
    logic [31:0]  addr   = '0;
    logic         rd     = 1'b0;
    logic         we     = 1'b0;
    logic [31:0]  wdata  = '0;
    logic [127:0] in_port = '0;
    logic [31:0]  io_read_data;
    logic         irq;

    logic [31:0]  addr8   = '0;
    logic         rd8     = 1'b0;
    logic         we8     = 1'b0;
    logic [31:0]  wdata8  = '0;
    logic [15:0]  in_port8 = 16'hA55A;
    logic [31:0]  rdata8;
    logic         irq8;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [127:0] m_hist[$];
    logic [31:0]  m_in_reg [NP];
    logic [3:0]   m_chg;
    logic [3:0]   m_mask;
    logic         m_irq;

    always #50 io_clk = ~io_clk;

    io_input_bank #(.NPORTS(NP), .WIDTH(W), .SYNC_STAGES(SYNC)) u_dut (
        .io_clk(io_clk), .reset(reset), .addr(addr), .rd(rd), .we(we),
        .wdata(wdata), .in_port(in_port), .io_read_data(io_read_data), .irq(irq)
    );

    io_input_bank #(.NPORTS(2), .WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
        .io_clk(io_clk), .reset(reset), .addr(addr8), .rd(rd8), .we(we8),
        .wdata(wdata8), .in_port(in_port8), .io_read_data(rdata8), .irq(irq8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_hist.delete();
        for (int i = 0; i < NP; i++) m_in_reg[i] = '0;
        m_chg  = '0;
        m_mask = '0;
        m_irq  = 1'b0;
    endfunction

    // Expected read value from the address map rules.
    function automatic logic [31:0] model_read(input logic [31:0] a);
        int s;
        s = int'(a[7:2]);
        if (s >= 48 && s < 48 + NP) return m_in_reg[s-48];
        if (s == 48 + NP) return {28'b0, m_chg};
        if (s == 48 + NP + 1) return {28'b0, m_mask};
        return 32'h0;
    endfunction

    // One clock edge: the port register shows the input from SYNC edges ago.
    function automatic void model_edge();
        logic [31:0]  nxt [NP];
        logic [127:0] old;
        logic [3:0]   setv;
        logic [3:0]   clr;
        old = (m_hist.size() >= SYNC) ? m_hist[m_hist.size()-SYNC] : '0;
        for (int i = 0; i < NP; i++) begin
            nxt[i]  = old[i*32 +: 32];
            setv[i] = (nxt[i] != m_in_reg[i]);
        end
        clr    = (rd && addr[7:2] == 6'(48 + NP)) ? m_chg : 4'h0;
        m_chg  = (m_chg & ~clr) | setv;
        if (we && addr[7:2] == 6'(48 + NP + 1)) m_mask = wdata[3:0];
        m_irq  = |(m_chg & m_mask);
        for (int i = 0; i < NP; i++) m_in_reg[i] = nxt[i];
        m_hist.push_back(in_port);
        if (m_hist.size() > SYNC) void'(m_hist.pop_front());
    endfunction

    // Drive one cycle's inputs, check combinational outputs, then clock.
    task automatic cycle(input logic [31:0] a, input logic r, input logic w,
                         input logic [31:0] wd, input logic [127:0] pin);
        addr = a; rd = r; we = w; wdata = wd; in_port = pin;
        #1;
        check("rdata", io_read_data, model_read(a));
        check("irq", 32'(irq), 32'(m_irq));
        model_edge();
        @(posedge io_clk);
        @(negedge io_clk);
    endtask

    // Side-effect-free peek against a literal expectation.
    task automatic expect_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a; rd = 1'b0; we = 1'b0;
        #1;
        check(tag, io_read_data, exp);
    endtask

    logic [127:0] pin;
    logic [31:0]  ra;
    logic [31:0]  rnd;

    initial begin
        model_reset();
        repeat (2) @(negedge io_clk);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        pin = '0;

        // Idle after reset: everything reads zero.
        for (int c = 0; c < 5; c++) cycle(32'hC0 + 32'(c * 4), 1'b0, 1'b0, '0, pin);
        expect_read("idle_status", 32'hD0, 32'h0);
        expect_read("idle_unmapped", 32'hFC, 32'h0);
        check("idle_irq", 32'(irq), 32'h0);

        // Port 2 latency: visible two edges after it is sampled.
        pin[64 +: 32] = 32'hDEADBEEF;
        cycle(32'hC8, 1'b0, 1'b0, '0, pin);
        expect_read("p2_e", 32'hC8, 32'h0);
        cycle(32'hC8, 1'b0, 1'b0, '0, pin);
        expect_read("p2_e1", 32'hC8, 32'h0);
        cycle(32'hC8, 1'b0, 1'b0, '0, pin);
        expect_read("p2_e2", 32'hC8, 32'hDEADBEEF);
        expect_read("status_p2", 32'hD0, 32'h4);

        // Clear, set mask, then a masked change raises irq at E+2.
        cycle(32'hD0, 1'b1, 1'b0, '0, pin);
        cycle(32'hD4, 1'b0, 1'b1, 32'h4, pin);
        check("mask_irq0", 32'(irq), 32'h0);
        expect_read("mask_rd", 32'hD4, 32'h4);
        pin[64 +: 32] = 32'h12345678;
        cycle(32'hC8, 1'b0, 1'b0, '0, pin);
        cycle(32'hC8, 1'b0, 1'b0, '0, pin);
        check("irq_e1", 32'(irq), 32'h0);
        cycle(32'hC8, 1'b0, 1'b0, '0, pin);
        check("irq_e2", 32'(irq), 32'h1);
        expect_read("status_p2b", 32'hD0, 32'h4);
        cycle(32'hD0, 1'b1, 1'b0, '0, pin);
        expect_read("status_clr", 32'hD0, 32'h0);
        check("irq_clr", 32'(irq), 32'h0);

        // Set wins over a simultaneous clear of the same bit.
        pin[32 +: 32] = 32'h0000AAAA;
        repeat (3) cycle(32'hC4, 1'b0, 1'b0, '0, pin);
        pin[32 +: 32] = 32'h0000BBBB;
        cycle(32'h0, 1'b0, 1'b0, '0, pin);
        cycle(32'h0, 1'b0, 1'b0, '0, pin);
        cycle(32'hD0, 1'b1, 1'b0, '0, pin);
        expect_read("set_wins", 32'hD0, 32'h2);

        // Asynchronous reset with all flags and mask set.
        cycle(32'hD4, 1'b0, 1'b1, 32'hF, pin);
        pin = {32'h4, 32'h3, 32'h2, 32'h1};
        repeat (3) cycle(32'h0, 1'b0, 1'b0, '0, pin);
        expect_read("pre_rst_status", 32'hD0, 32'hF);
        expect_read("pre_rst_mask", 32'hD4, 32'hF);
        check("pre_rst_irq", 32'(irq), 32'h1);
        #2 reset = 1'b1;
        expect_read("arst_status", 32'hD0, 32'h0);
        expect_read("arst_mask", 32'hD4, 32'h0);
        for (int i = 0; i < NP; i++) expect_read("arst_port", 32'hC0 + 32'(i * 4), 32'h0);
        check("arst_irq", 32'(irq), 32'h0);
        model_reset();
        @(negedge io_clk);
        reset = 1'b0;

        // Randomised traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(3) == 0) begin
                    rnd = $urandom;
                    pin[i*32 +: 32] = ($urandom_range(1) == 0) ? (rnd & 32'h3) : rnd;
                end
            end
            rnd = $urandom;
            ra  = rnd;
            if ($urandom_range(4) != 0) ra[7:2] = 6'(48 + $urandom_range(NP + 1));
            cycle(ra, ($urandom_range(2) == 0), ($urandom_range(3) == 0), $urandom, pin);
        end

        // Narrow instance: zero-extension, unmapped select, flags from reset.
        addr8 = 32'hC0; #1; check("w8_p0", rdata8, 32'h0000005A);
        addr8 = 32'hC4; #1; check("w8_p1", rdata8, 32'h000000A5);
        addr8 = 32'hFC; #1; check("w8_unmapped", rdata8, 32'h0);
        addr8 = 32'hC8; #1; check("w8_status", rdata8, 32'h3);
        addr8 = 32'hCC; #1; check("w8_mask", rdata8, 32'h0);
        check("w8_irq", 32'(irq8), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/io_input_bank.md
# io_input_bank

Parametrised memory-mapped input bank that replaces the fixed two-port input register. It samples NPORTS external input ports through a configurable synchroniser and latches each into a port register. It tracks per-port change events in a sticky status register that is cleared on read, and raises a maskable, registered interrupt. It sits on the CPU's I/O read path, selected by word address bits addr[7:2], alongside the output port block.

## Interface

Parameters:

- NPORTS, 4: number of input ports. Legal range is 1..14 with the default BASE_SEL.
- WIDTH, 32: width of each port, 1..32. Narrower ports read back zero-extended to 32 bits.
- SYNC_STAGES, 2: depth of the synchroniser flop chain per port, at least 1.
- BASE_SEL, 6'b110000: addr[7:2] value of port 0. BASE_SEL+NPORTS+1 must be at most 63.

Ports (name, direction, width, meaning):

- io_clk, input, 1: the single clock for the block.
- reset, input, 1: asynchronous, active-high reset.
- addr, input, 32: byte address. Only addr[7:2] is decoded.
- rd, input, 1: read strobe. Qualifies the clear-on-read of the status register.
- we, input, 1: write strobe. Used only for the mask register.
- wdata, input, 32: write data for the mask register.
- in_port, input, NPORTS*WIDTH: flattened external inputs. Port i occupies bits [i*WIDTH +: WIDTH].
- io_read_data, output, 32: combinational read data.
- irq, output, 1: registered interrupt request.

## Operation

Address map, decoded from sel = addr[7:2]:

- sel = BASE_SEL+i, for i < NPORTS: reads port register i (in_reg[i]), zero-extended to 32 bits.
- sel = BASE_SEL+NPORTS: STATUS register. Bits [NPORTS-1:0] are the sticky change flags; all higher bits read 0.
- sel = BASE_SEL+NPORTS+1: MASK register. Bits [NPORTS-1:0] are read/write; all higher bits read 0 and ignore writes.
- Any other sel reads 32'h0. The bank never falls back to port 0.

Per-port datapath:

- Each port passes through a chain of SYNC_STAGES flops, s[1] through s[SYNC_STAGES].
- On every clock edge, in_reg[i] <= s[SYNC_STAGES]. The register reloads every cycle; there is no enable.
- chg[i] sets on any edge where s[SYNC_STAGES] != in_reg[i], i.e. the port register is about to change value.

STATUS clear-on-read:

- A cycle with rd=1 and sel=STATUS clears the chg bits that were 1 in the value returned that cycle.
- If a bit is set and cleared on the same edge, set wins and the bit stays 1.
- A read with rd=0 (a combinational peek) has no side effect.

MASK register:

- A cycle with we=1 and sel=MASK writes mask <= wdata[NPORTS-1:0].
- A we at any other address is ignored. Input ports are read-only.

Interrupt:

- On every edge, irq <= |(chg_next & mask_next), i.e. computed from the values of chg and mask being registered on that same edge.

Reset:

- reset asynchronously clears every sync flop, in_reg, chg, mask and irq to 0. io_read_data then reflects these zero values.
- After reset deasserts, a nonzero input sets its chg bit when it first reaches in_reg. This is intended behaviour, not suppressed.
- Asserting reset mid-operation discards any in-flight samples and pending flags.

## Timing

- An input change that is stable before io_clk edge E appears in in_reg and sets chg at edge E+SYNC_STAGES. With default parameters this is E+2.
- irq rises on that same edge when the corresponding mask bit is 1. This follows from irq being computed from chg_next.
- io_read_data has zero-cycle latency from addr. It is valid in the same cycle addr is presented.
- A STATUS read with rd=1 takes effect at the following edge. irq falls at that same edge if no masked bit remains set.
- A MASK write takes effect at the following edge, and irq updates at that same edge.
- A pulse shorter than one clock period may be missed. A value that toggles and returns within one cycle is never flagged.

## Test plan

- Reset, then hold all inputs at 0 for 5 cycles. Require: every read returns 0, STATUS = 0, irq = 0.
- Defaults (NPORTS=4, WIDTH=32, SYNC_STAGES=2). Drive port 2 to 32'hDEADBEEF before edge E. Require: reading addr 32'h000000C8 returns 32'hDEADBEEF from edge E+2, and STATUS = 4'b0100.
- Write MASK = 4'b0100 via we at addr 32'h000000D4, then change port 2. Require: irq = 1 at edge E+2. A STATUS read with rd=1 returns 32'h4; STATUS and irq are both 0 at the next edge.
- Change port 1 on the same edge a STATUS read with rd=1 clears bit 1. Require: bit 1 remains 1 afterward (set wins).
- WIDTH=8, NPORTS=2, in_port = 16'hA55A. Require: port 0 reads 32'h0000005A, port 1 reads 32'h000000A5, and unmapped sel 6'b111111 reads 0.
- Assert reset mid-stream with STATUS = 4'b1111 and MASK = 4'b1111. Require: STATUS, MASK, irq and all in_reg values are 0 immediately, without waiting for a clock edge.
